// File: rtl/result_writeback.sv
// Result writeback buffer: queues (address, result) pairs from the operation stage
// and drains them into the result memory while tracking commits for checker alignment.
module result_writeback #(
   parameter int MEM_WIDTH  = 32,
   parameter int MEM_DEPTH  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         result_valid_i,
   output logic                         result_ready_o,
   input  logic [MEM_WIDTH-1:0]         result_i,
   input  logic [$clog2(MEM_DEPTH)-1:0] result_addr_i,
   output logic                         mem_we_o,
   input  logic                         mem_ready_i,
   output logic [$clog2(MEM_DEPTH)-1:0] mem_addr_o,
   output logic [MEM_WIDTH-1:0]         mem_data_o,
   output logic [$clog2(MEM_DEPTH):0]   commit_count_o,
   output logic [$clog2(MEM_DEPTH)-1:0] last_commit_addr_o,
   output logic [MEM_WIDTH-1:0]         last_commit_data_o,
   output logic                         overwrite_o,
   output logic                         done_o
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int SW = ((CW > PW + 1) ? CW : PW + 1) + 1;
   localparam logic [PW:0]   FULL_CNT = FIFO_DEPTH[PW:0];
   localparam logic [CW-1:0] CNT_MAX  = MEM_DEPTH[CW-1:0];
   localparam logic [SW-1:0] SUM_MAX  = MEM_DEPTH[SW-1:0];

   typedef enum logic [1:0] {ACTIVE, DRAIN, DONE} state_t;
   state_t state, state_next;

   logic [AW-1:0]        fifo_addr [FIFO_DEPTH];
   logic [MEM_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [PW:0]          count, count_next;
   logic [CW-1:0]        commit_next;
   logic [SW-1:0]        total_next;
   logic [MEM_DEPTH-1:0] written;
   logic                 full, empty, push, pop;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // Handshake outputs depend only on registered state and reset, never on mem_ready_i.
   assign result_ready_o = !rst_i && (state == ACTIVE) && !full;
   assign mem_we_o       = !rst_i && (state != DONE) && !empty;
   assign push           = result_valid_i && result_ready_o;
   assign pop            = mem_we_o && mem_ready_i;
   assign mem_addr_o     = fifo_addr[rd_ptr];
   assign mem_data_o     = fifo_data[rd_ptr];

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
      commit_next = commit_count_o + {{(CW-1){1'b0}}, pop};
      total_next  = SW'(commit_next) + SW'(count_next);
   end

   // Stop accepting once everything needed to complete the run is already in flight.
   always_comb begin
      state_next = state;
      case (state)
         ACTIVE:  if (push && (total_next >= SUM_MAX)) state_next = DRAIN;
         DRAIN:   if (pop && (commit_next == CNT_MAX)) state_next = DONE;
         default: state_next = state;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_addr[wr_ptr] <= result_addr_i;
         fifo_data[wr_ptr] <= result_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state              <= ACTIVE;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         count              <= '0;
         commit_count_o     <= '0;
         last_commit_addr_o <= '0;
         last_commit_data_o <= '0;
         overwrite_o        <= 1'b0;
         done_o             <= 1'b0;
         written            <= '0;
      end else begin
         state          <= state_next;
         count          <= count_next;
         commit_count_o <= commit_next;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr                  <= rd_ptr + 1'b1;
            last_commit_addr_o      <= mem_addr_o;
            last_commit_data_o      <= mem_data_o;
            written[mem_addr_o]     <= 1'b1;
            if (written[mem_addr_o]) overwrite_o <= 1'b1;
         end
         if ((state == DRAIN) && (state_next == DONE)) done_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: fill/drain, backpressure, overwrite, reset and
// a toggling-ready run with a push-order scoreboard.
module tb_result_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic        ready;
   logic [31:0] data;
   logic [2:0]  addr;
   logic        mem_we;
   logic        mem_ready;
   logic [2:0]  mem_addr;
   logic [31:0] mem_data;
   logic [3:0]  commit_count;
   logic [2:0]  last_addr;
   logic [31:0] last_data;
   logic        overwrite;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   result_writeback #(.MEM_WIDTH(32), .MEM_DEPTH(8), .FIFO_DEPTH(4)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .result_valid_i     (valid),
      .result_ready_o     (ready),
      .result_i           (data),
      .result_addr_i      (addr),
      .mem_we_o           (mem_we),
      .mem_ready_i        (mem_ready),
      .mem_addr_o         (mem_addr),
      .mem_data_o         (mem_data),
      .commit_count_o     (commit_count),
      .last_commit_addr_o (last_addr),
      .last_commit_data_o (last_data),
      .overwrite_o        (overwrite),
      .done_o             (done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid = 1'b0;
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      logic [15:0] gap_pat;
      int sent;
      int got;
      logic do_push;
      logic do_pop;

      rst = 1'b1; valid = 1'b0; data = '0; addr = '0; mem_ready = 1'b0;
      tick();
      tick();
      check("rst_ready", ready, 0);
      check("rst_we", mem_we, 0);
      check("rst_count", commit_count, 0);
      check("rst_last_addr", last_addr, 0);
      check("rst_last_data", last_data, 0);
      check("rst_flags", {overwrite, done}, 0);
      rst = 1'b0;
      #1;
      check("rst_release_ready", ready, 1);

      // Streaming fill, one commit per cycle
      mem_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         valid = 1'b1; addr = 3'(i); data = 32'(10 * (i + 1));
         tick();
         check("stream_we", mem_we, 1);
         check("stream_addr", mem_addr, i);
         check("stream_data", mem_data, 10 * (i + 1));
         check("stream_count", commit_count, i);
      end
      valid = 1'b0;
      check("stream_drain_ready", ready, 0);
      tick();
      check("stream_final_count", commit_count, 8);
      check("stream_last_addr", last_addr, 7);
      check("stream_last_data", last_data, 80);
      check("stream_done", done, 1);
      check("stream_overwrite", overwrite, 0);
      valid = 1'b1;
      tick();
      tick();
      check("done_ready_low", ready, 0);
      check("done_we_low", mem_we, 0);
      check("done_count_hold", commit_count, 8);
      valid = 1'b0;

      // Backpressure: fill the buffer with memory stalled
      do_reset();
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("bp_ready_before", ready, 1);
         valid = 1'b1; addr = 3'(i); data = 32'(100 + i);
         tick();
      end
      check("bp_full_ready", ready, 0);
      check("bp_we", mem_we, 1);
      check("bp_head_addr", mem_addr, 0);
      check("bp_head_data", mem_data, 100);
      valid = 1'b1; addr = 3'd4; data = 32'd104;
      tick();
      tick();
      check("bp_hold_addr", mem_addr, 0);
      check("bp_hold_data", mem_data, 100);
      check("bp_hold_count", commit_count, 0);

      // Full with pop and push offered together: only the pop happens
      mem_ready = 1'b1;
      tick();
      check("fullpop_count", commit_count, 1);
      check("fullpop_last", {last_addr, last_data}, {3'd0, 32'd100});
      check("fullpop_ready_rises", ready, 1);
      check("fullpop_next_head", mem_data, 101);
      mem_ready = 1'b0;
      tick();
      check("refill_ready", ready, 0);
      check("refill_count", commit_count, 1);
      valid = 1'b0;
      mem_ready = 1'b1;
      for (int j = 1; j < 5; j++) begin
         tick();
         check("bp_order_addr", last_addr, j);
         check("bp_order_data", last_data, 100 + j);
         check("bp_order_count", commit_count, j + 1);
      end
      check("bp_empty_we", mem_we, 0);
      check("bp_empty_ready", ready, 1);

      // Overwrite detection on a repeated address
      do_reset();
      mem_ready = 1'b1;
      valid = 1'b1; addr = 3'd3; data = 32'd5;
      tick();
      addr = 3'd3; data = 32'd9;
      tick();
      valid = 1'b0;
      check("ow_first_flag", overwrite, 0);
      check("ow_first_data", last_data, 5);
      tick();
      check("ow_flag", overwrite, 1);
      check("ow_last", {last_addr, last_data}, {3'd3, 32'd9});
      check("ow_count", commit_count, 2);
      tick();
      check("ow_sticky", overwrite, 1);

      // Reset with entries buffered
      mem_ready = 1'b0;
      for (int i = 5; i < 8; i++) begin
         valid = 1'b1; addr = 3'(i); data = 32'(200 + i);
         tick();
      end
      valid = 1'b0;
      check("pre_rst_count", commit_count, 2);
      check("pre_rst_we", mem_we, 1);
      rst = 1'b1;
      tick();
      check("mid_rst_we", mem_we, 0);
      check("mid_rst_count", commit_count, 0);
      check("mid_rst_flags", {overwrite, done}, 0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", ready, 1);
      check("post_rst_discard", mem_we, 0);

      // Toggling memory ready with gaps in the upstream stream
      gap_pat = 16'b1011_0010_1110_0101;
      sent = 0;
      got = 0;
      for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
         mem_ready = cyc[0];
         valid = (sent < 8) && gap_pat[cyc % 16];
         addr = 3'(sent);
         data = 32'(1000 + sent * 7);
         do_push = valid && ready;
         do_pop = mem_we && mem_ready;
         if (do_pop) begin
            check("rand_commit_addr", mem_addr, got);
            check("rand_commit_data", mem_data, 1000 + got * 7);
         end
         tick();
         if (do_push) sent++;
         if (do_pop) begin
            got++;
            check("rand_done_timing", done, (got == 8));
         end
      end
      valid = 1'b0;
      check("rand_commits_seen", got, 8);
      check("rand_count", commit_count, 8);
      check("rand_done", done, 1);
      check("rand_no_overwrite", overwrite, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
